dgain_agc_ctrl: RTL and testbench

- Frame-rate automatic gain controller for the 48-bit→16-bit digital gain stage.
- Once per frame (`ms_in` strobe) it takes the signed 48-bit peak reported by the peak detector and derives the 16-bit `scaled_coeff` (bit-select offset) that drives the adjust stage.
- It applies the same coefficient to all lanes, with guard headroom, clipping, attack/decay asymmetry and a manual override.

---
 rtl/dgain_pkg.sv | 32 +++
 rtl/lead_one_enc48.sv | 34 +++
 rtl/dgain_agc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dgain_agc_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dgain_pkg.sv
// Shared definitions for the digital-gain AGC controller: widths, the
// frame-evaluation state encoding and the coefficient clip helper.
package dgain_pkg;

    localparam int DATA_W  = 48;
    localparam int OUT_W   = 16;
    localparam int COEFF_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAG    = 2'd1,
        ENC    = 2'd2,
        DECIDE = 2'd3
    } state_e;

    // Clamp a signed candidate offset into [0, cmax].
    function automatic logic [COEFF_W-1:0] clip_coeff(
        input logic signed [7:0] raw,
        input logic signed [7:0] cmax
    );
        logic [COEFF_W-1:0] res;
        if (raw < 8'sd0) begin
            res = {COEFF_W{1'b0}};
        end else if (raw > cmax) begin
            res = cmax[COEFF_W-1:0];
        end else begin
            res = raw[COEFF_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/lead_one_enc48.sv
// Registered leading-one encoder over a 47-bit magnitude. Output w is the
// index of the highest set bit plus one, or 0 for an all-zero magnitude.
// The register only loads when en is high, so a discarded evaluation leaves
// the previously reported width in place.
module lead_one_enc48
    import dgain_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [46:0] mag,
    output logic [5:0]  w
);

    logic [5:0] w_s;

    // Priority scan from LSB upward; the last set bit seen wins.
    always_comb begin
        w_s = 6'd0;
        for (int i = 0; i < 47; i++) begin
            w_s = mag[i] ? 6'(i + 1) : w_s;
        end
    end

    // ENC-stage register holding the encoded width.
    always_ff @(posedge clk) begin
        if (rst) begin
            w <= 6'd0;
        end else if (en) begin
            w <= w_s;
        end
    end

endmodule

// File: rtl/dgain_agc_ctrl.sv
// Frame-rate automatic gain controller for the 48-bit to 16-bit gain stage.
// Each ms_in strobe launches a 3-stage evaluation (MAG, ENC, DECIDE) of the
// frame peak and produces the bit-select offset scaled_coeff.
// Optional feature macro: DGAIN_AGC_DECAY_EN (when defined, a lower
// coefficient is only applied after DECAY_FRAMES consecutive lower frames;
// when undefined, every automatic decision is applied immediately).
module dgain_agc_ctrl
    import dgain_pkg::*;
#(
    parameter int HEADROOM     = 1,
    parameter int COEFF_MAX    = 32,
    parameter int DECAY_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ms_in,
    input  logic [DATA_W-1:0]   max_in,
    input  logic                manual_en,
    input  logic [COEFF_W-1:0]  manual_coeff,
    output logic [OUT_W-1:0]    scaled_coeff,
    output logic                coeff_upd,
    output logic                busy,
    output logic [5:0]          peak_width
);

    state_e              state_r;
    state_e              state_s;
    logic [DATA_W-1:0]   cap_r;
    logic [DATA_W-2:0]   mag_r;
    logic [5:0]          peak_w_s;
    logic [COEFF_W-1:0]  coeff_r;
    logic [COEFF_W-1:0]  coeff_s;
    logic                upd_r;
    logic                upd_s;
    logic                busy_r;
    logic                enc_en_s;
    logic                decide_s;
    logic signed [7:0]   raw_s;
    logic [COEFF_W-1:0]  new_s;
    logic [COEFF_W-1:0]  man_clip_s;
    logic                decay_write_s;

    // A strobe mid-evaluation aborts it, so every stage load is qualified
    // with !ms_in.
    assign enc_en_s = (state_r == ENC) && !ms_in;
    assign decide_s = (state_r == DECIDE) && !ms_in;

    // Candidate offset: w + 1 + HEADROOM - OUT_W, evaluated signed.
    assign raw_s      = $signed({2'b00, peak_w_s}) + $signed(8'(HEADROOM + 1 - OUT_W));
    assign new_s      = clip_coeff(raw_s, 8'(COEFF_MAX));
    assign man_clip_s = clip_coeff($signed({2'b00, manual_coeff}), 8'(COEFF_MAX));

    // Next-state logic: strobe always restarts at MAG, otherwise walk the pipe.
    always_comb begin
        state_s = state_r;
        if (ms_in) begin
            state_s = MAG;
        end else begin
            case (state_r)
                IDLE:    state_s = IDLE;
                MAG:     state_s = ENC;
                ENC:     state_s = DECIDE;
                DECIDE:  state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Peak capture on every strobe (including an aborting one).
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_r <= {DATA_W{1'b0}};
        end else if (ms_in) begin
            cap_r <= max_in;
        end
    end

    // MAG stage: one's-complement magnitude so -2^47 cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r <= {(DATA_W-1){1'b0}};
        end else if ((state_r == MAG) && !ms_in) begin
            mag_r <= cap_r[DATA_W-1] ? ~cap_r[DATA_W-2:0] : cap_r[DATA_W-2:0];
        end
    end

    lead_one_enc48 u_enc (
        .clk (clk),
        .rst (rst),
        .en  (enc_en_s),
        .mag (mag_r),
        .w   (peak_w_s)
    );

`ifdef DGAIN_AGC_DECAY_EN
    logic [3:0] cnt_r;
    logic [3:0] cnt_inc_s;

    // Saturating count of consecutive lower frames, including this one.
    always_comb begin
        cnt_inc_s     = (cnt_r == 4'd15) ? 4'd15 : (cnt_r + 4'd1);
        decay_write_s = (cnt_inc_s >= 4'(DECAY_FRAMES));
    end

    // Decay counter: cleared on any write, advanced on a decay hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (decide_s) begin
            if (manual_en || (new_s >= coeff_r) || decay_write_s) begin
                cnt_r <= 4'd0;
            end else begin
                cnt_r <= cnt_inc_s;
            end
        end
    end
`else
    assign decay_write_s = 1'b1;
`endif

    // DECIDE: manual override, attack, or (possibly deferred) decay.
    always_comb begin
        coeff_s = coeff_r;
        upd_s   = 1'b0;
        if (decide_s) begin
            if (manual_en) begin
                coeff_s = man_clip_s;
                upd_s   = 1'b1;
            end else if ((new_s >= coeff_r) || decay_write_s) begin
                coeff_s = new_s;
                upd_s   = 1'b1;
            end else begin
                coeff_s = coeff_r;
                upd_s   = 1'b0;
            end
        end else begin
            coeff_s = coeff_r;
            upd_s   = 1'b0;
        end
    end

    // Output coefficient and update pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_r <= {COEFF_W{1'b0}};
            upd_r   <= 1'b0;
        end else begin
            coeff_r <= coeff_s;
            upd_r   <= upd_s;
        end
    end

    assign scaled_coeff = {{(OUT_W-COEFF_W){1'b0}}, coeff_r};
    assign coeff_upd    = upd_r;
    assign busy         = busy_r;
    assign peak_width   = peak_w_s;

endmodule

// File: tb/tb_dgain_agc_ctrl.sv
// Directed bench for dgain_agc_ctrl: a table of per-frame vectors plus
// hand-written abort and mid-evaluation reset sequences.
module tb_dgain_agc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ms_in;
    logic [47:0] max_in;
    logic        manual_en;
    logic [5:0]  manual_coeff;
    logic [15:0] scaled_coeff;
    logic        coeff_upd;
    logic        busy;
    logic [5:0]  peak_width;

    int n_cmp  = 0;
    int n_fail = 0;

    dgain_agc_ctrl #(
        .HEADROOM     (1),
        .COEFF_MAX    (32),
        .DECAY_FRAMES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ms_in        (ms_in),
        .max_in       (max_in),
        .manual_en    (manual_en),
        .manual_coeff (manual_coeff),
        .scaled_coeff (scaled_coeff),
        .coeff_upd    (coeff_upd),
        .busy         (busy),
        .peak_width   (peak_width)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        man;
        logic [5:0]  mc;
        logic [47:0] peak;
        logic [5:0]  w;
        logic [5:0]  c_dec;
        logic        u_dec;
        logic [5:0]  c_nod;
        logic        u_nod;
    } vec_t;

    vec_t vecs [23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [5:0] ec;
        logic       eu;

        // man, mc, peak, w, coeff/upd with decay, coeff/upd without decay
        vecs[0]  = '{1'b0, 6'd0,  48'h0000_0000_7FFF, 6'd15, 6'd1,  1'b1, 6'd1,  1'b1};
        vecs[1]  = '{1'b0, 6'd0,  48'h7FFF_FFFF_FFFF, 6'd47, 6'd32, 1'b1, 6'd32, 1'b1};
        vecs[2]  = '{1'b0, 6'd0,  48'hFFFF_FFFF_FFFF, 6'd0,  6'd32, 1'b0, 6'd0,  1'b1};
        vecs[3]  = '{1'b0, 6'd0,  48'hFFFF_FFFF_FFFF, 6'd0,  6'd32, 1'b0, 6'd0,  1'b1};
        vecs[4]  = '{1'b0, 6'd0,  48'hFFFF_FFFF_FFFF, 6'd0,  6'd32, 1'b0, 6'd0,  1'b1};
        vecs[5]  = '{1'b0, 6'd0,  48'hFFFF_FFFF_FFFF, 6'd0,  6'd0,  1'b1, 6'd0,  1'b1};
        vecs[6]  = '{1'b0, 6'd0,  48'hFFFF_FFF0_0000, 6'd20, 6'd6,  1'b1, 6'd6,  1'b1};
        vecs[7]  = '{1'b0, 6'd0,  48'h8000_0000_0000, 6'd47, 6'd32, 1'b1, 6'd32, 1'b1};
        vecs[8]  = '{1'b1, 6'd40, 48'h0000_0000_7FFF, 6'd15, 6'd32, 1'b1, 6'd32, 1'b1};
        vecs[9]  = '{1'b1, 6'd10, 48'h0000_0000_0000, 6'd0,  6'd10, 1'b1, 6'd10, 1'b1};
        vecs[10] = '{1'b0, 6'd0,  48'h0000_0002_0000, 6'd18, 6'd10, 1'b0, 6'd4,  1'b1};
        vecs[11] = '{1'b0, 6'd0,  48'h0000_0002_0000, 6'd18, 6'd10, 1'b0, 6'd4,  1'b1};
        vecs[12] = '{1'b0, 6'd0,  48'h0000_0002_0000, 6'd18, 6'd10, 1'b0, 6'd4,  1'b1};
        vecs[13] = '{1'b0, 6'd0,  48'h0000_0200_0000, 6'd26, 6'd12, 1'b1, 6'd12, 1'b1};
        vecs[14] = '{1'b0, 6'd0,  48'h0000_0002_0000, 6'd18, 6'd12, 1'b0, 6'd4,  1'b1};
        vecs[15] = '{1'b0, 6'd0,  48'h0000_0002_0000, 6'd18, 6'd12, 1'b0, 6'd4,  1'b1};
        vecs[16] = '{1'b0, 6'd0,  48'h0000_0002_0000, 6'd18, 6'd12, 1'b0, 6'd4,  1'b1};
        vecs[17] = '{1'b0, 6'd0,  48'h0000_0002_0000, 6'd18, 6'd4,  1'b1, 6'd4,  1'b1};
        vecs[18] = '{1'b0, 6'd0,  48'h0000_0000_8000, 6'd16, 6'd4,  1'b0, 6'd2,  1'b1};
        vecs[19] = '{1'b0, 6'd0,  48'h0000_0000_8000, 6'd16, 6'd4,  1'b0, 6'd2,  1'b1};
        vecs[20] = '{1'b0, 6'd0,  48'h0000_0000_8000, 6'd16, 6'd4,  1'b0, 6'd2,  1'b1};
        vecs[21] = '{1'b1, 6'd4,  48'h0000_0000_8000, 6'd16, 6'd4,  1'b1, 6'd4,  1'b1};
        vecs[22] = '{1'b0, 6'd0,  48'h0000_0000_8000, 6'd16, 6'd4,  1'b0, 6'd2,  1'b1};

        rst          = 1'b1;
        ms_in        = 1'b0;
        max_in       = 48'h0;
        manual_en    = 1'b0;
        manual_coeff = 6'd0;
        step();
        step();
        chk("reset coeff", {32'h0, scaled_coeff}, 48'h0);
        chk("reset upd",   {47'h0, coeff_upd},    48'h0);
        chk("reset busy",  {47'h0, busy},         48'h0);
        chk("reset width", {42'h0, peak_width},   48'h0);
        rst = 1'b0;
        step();

        // Table-driven frames at minimum spacing (strobe every 4 cycles).
        for (int i = 0; i < 23; i++) begin
`ifdef DGAIN_AGC_DECAY_EN
            ec = vecs[i].c_dec;
            eu = vecs[i].u_dec;
`else
            ec = vecs[i].c_nod;
            eu = vecs[i].u_nod;
`endif
            manual_en    = vecs[i].man;
            manual_coeff = vecs[i].mc;
            max_in       = vecs[i].peak;
            ms_in        = 1'b1;
            step();
            ms_in = 1'b0;
            chk($sformatf("v%0d busy1", i), {47'h0, busy}, 48'h1);
            chk($sformatf("v%0d upd1", i), {47'h0, coeff_upd}, 48'h0);
            step();
            chk($sformatf("v%0d busy2", i), {47'h0, busy}, 48'h1);
            step();
            chk($sformatf("v%0d busy3", i), {47'h0, busy}, 48'h1);
            chk($sformatf("v%0d upd3", i), {47'h0, coeff_upd}, 48'h0);
            step();
            chk($sformatf("v%0d coeff", i), {32'h0, scaled_coeff}, {42'h0, ec});
            chk($sformatf("v%0d upd", i), {47'h0, coeff_upd}, {47'h0, eu});
            chk($sformatf("v%0d width", i), {42'h0, peak_width}, {42'h0, vecs[i].w});
            chk($sformatf("v%0d busy4", i), {47'h0, busy}, 48'h0);
        end

        // Abort: second strobe two cycles later replaces the first peak.
        manual_en = 1'b0;
        max_in    = 48'h7FFF_FFFF_FFFF;
        ms_in     = 1'b1;
        step();
        ms_in = 1'b0;
        chk("abort busy1", {47'h0, busy}, 48'h1);
        step();
        chk("abort busy2", {47'h0, busy}, 48'h1);
        max_in = 48'h0000_0200_0000;
        ms_in  = 1'b1;
        step();
        ms_in = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            chk($sformatf("abort busy%0d", k), {47'h0, busy}, 48'h1);
            chk($sformatf("abort upd%0d", k), {47'h0, coeff_upd}, 48'h0);
            step();
        end
        chk("abort upd6",   {47'h0, coeff_upd},    48'h1);
        chk("abort coeff",  {32'h0, scaled_coeff}, 48'd12);
        chk("abort width",  {42'h0, peak_width},   48'd26);
        chk("abort busy6",  {47'h0, busy},         48'h0);
        step();

        // Reset in the middle of an evaluation: no update afterwards.
        max_in = 48'h7FFF_FFFF_FFFF;
        ms_in  = 1'b1;
        step();
        ms_in = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst coeff", {32'h0, scaled_coeff}, 48'h0);
        chk("midrst busy",  {47'h0, busy},         48'h0);
        chk("midrst width", {42'h0, peak_width},   48'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst upd%0d", k), {47'h0, coeff_upd}, 48'h0);
            step();
        end
        chk("midrst hold coeff", {32'h0, scaled_coeff}, 48'h0);

        // Fresh frame after reset behaves like the first basic frame.
        max_in = 48'h0000_0000_7FFF;
        ms_in  = 1'b1;
        step();
        ms_in = 1'b0;
        step();
        step();
        step();
        chk("post coeff", {32'h0, scaled_coeff}, 48'd1);
        chk("post upd",   {47'h0, coeff_upd},    48'h1);
        chk("post width", {42'h0, peak_width},   48'd15);
        step();
        chk("post upd off", {47'h0, coeff_upd}, 48'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
